serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial ripple adder: adds two WIDTH-bit operands one bit per clock, LSB first, through a single one-bit full-adder slice plus a registered carry.
- Sits directly upstream of the one-bit full adder, sequencing operand bits into it and collecting its sum and carry-out bits.
- Trades area for latency: one full-adder slice instead of WIDTH slices, WIDTH cycles per add.
- Start/done handshake; result held stable until the next completed operation.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request: capture a, b, cin and begin an add. Sampled only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  initial carry-in.
- busy  output  1  high while in ADD.
- done  output  1  one-cycle pulse when sum/cout are updated.
- sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, operand shift regs=0, carry reg=0, bit counter=0. Clears immediately, independent of clk.
- Reset mid-operation aborts the add: no done, sum/cout return to 0.
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 at edge E0 loads shift regs with a and b, carry reg with cin, counter with 0; goes to ADD.
  - start=0: stays in IDLE.
- ADD (busy=1): at each edge E1..E_WIDTH:
  - s = a_sr[0]^b_sr[0]^carry; c = majority(a_sr[0], b_sr[0], carry).
  - Shift s into MSB of the internal result shift reg; shift a_sr, b_sr right by 1.
  - carry<=c; counter++.
  - At edge E_WIDTH (counter==WIDTH-1): copy full result into sum, final c into cout; go to DONE.
- DONE: done=1 for exactly this one cycle, busy=0; next edge goes to IDLE unconditionally.
- Latency: done high in the cycle following edge E_WIDTH, i.e. WIDTH+1 edges after start is sampled. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while in ADD or DONE is ignored. Inputs a/b/cin are don't-care after E0.
- sum and cout change only at edge E_WIDTH (or reset); they are stable at all other times, including during a later operation.
- Wrap-around: the result is modulo 2^WIDTH, and overflow appears only on cout.
- busy and done are never high simultaneously.

Test Plan (WIDTH=8 unless noted):
- Reset then idle: rst_n low 2 cycles, release, start=0 for 20 cycles -> busy=0, done=0, sum=0x00, cout=0 throughout.
- Basic add: a=0x05, b=0x03, cin=0, start pulse 1 cycle -> busy high 8 cycles, done pulse in 9th cycle after start edge, sum=0x08, cout=0.
- Overflow/wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. The first result holds until the second done.
- Ignored start: start add of 0x10+0x20, then pulse start with a=0xAA, b=0x55 during ADD -> sum=0x30, cout=0, exactly one done pulse.
- Reset mid-operation: start 0x7F+0x01, drop rst_n after 4 ADD cycles -> busy, done, sum, cout go to 0 immediately, no done afterwards. A new start after release gives the correct result.
- Exhaustive WIDTH=4: all a, b in 0..15, cin in {0,1} back-to-back -> {cout, sum} == a+b+cin for all 512 cases, each with a done latency of 5 edges after the start edge.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder slice plus a carry register,
// consuming one operand bit per clock (LSB first) behind a start/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=2.
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_c;
    logic             c_c;
    logic             last_c;

    // One-bit full-adder slice fed by the operand shift registers and carry.
    assign s_c    = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_c    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last_c = (cnt == CW'(WIDTH - 1));

    // Sequencer: load operands, ripple one bit per cycle, publish result once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {s_c, res_sr[WIDTH-1:1]};
                    carry  <= c_c;
                    cnt    <= cnt + CW'(1);
                    if (last_c) begin
                        sum   <= {s_c, res_sr[WIDTH-1:1]};
                        cout  <= c_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder (WIDTH=8 and WIDTH=4 instances)
// against an arithmetic reference: {cout,sum} = a + b + cin.
module tb_serial_adder;

    logic clk;
    logic rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int checks;
    int errors;

    // Reference model state: last published result of the 8-bit instance.
    logic [7:0] exp_sum8;
    logic       exp_cout8;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One 8-bit add from a negedge; optionally pulses a junk start during ADD.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit junk);
        logic [8:0] ref_v;
        int n;
        ref_v = 9'(a) + 9'(b) + 9'(c);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = $urandom; b8 = $urandom; cin8 = 1'($urandom);
        n = 1;
        while (!done8 && n < 40) begin
            check("busy_in_add", 64'(busy8), 64'd1);
            check("done_in_add", 64'(done8), 64'd0);
            check("hold_sum", 64'(sum8), 64'(exp_sum8));
            check("hold_cout", 64'(cout8), 64'(exp_cout8));
            if (junk && n == 3) begin
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start8 = 1'b0;
        check("latency8", 64'(n), 64'd9);
        check("done8", 64'(done8), 64'd1);
        check("busy_at_done", 64'(busy8), 64'd0);
        check("sum8", 64'(sum8), 64'(ref_v[7:0]));
        check("cout8", 64'(cout8), 64'(ref_v[8]));
        exp_sum8  = ref_v[7:0];
        exp_cout8 = ref_v[8];
        @(negedge clk);
        check("done_one_pulse", 64'(done8), 64'd0);
        check("idle_busy", 64'(busy8), 64'd0);
    endtask

    // One 4-bit add from a negedge, checking latency and result.
    task automatic add4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] ref_v;
        int n;
        ref_v = 5'(a) + 5'(b) + 5'(c);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency4", 64'(n), 64'd5);
        check("result4", 64'({cout4, sum4}), 64'(ref_v));
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0;
        exp_sum8 = '0; exp_cout8 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        rst_n = 1'b0;

        // Reset, then idle with start low.
        #1;
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_sum", 64'(sum8), 64'd0);
        check("rst_cout", 64'(cout8), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_state", 64'({busy8, done8, cout8, sum8}), 64'd0);
        end

        // Directed cases.
        add8(8'h05, 8'h03, 1'b0, 1'b0);
        add8(8'hFF, 8'h01, 1'b0, 1'b0);
        add8(8'hFF, 8'hFF, 1'b1, 1'b0);
        add8(8'h10, 8'h20, 1'b0, 1'b1);

        // Reset in the middle of an add.
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 64'(busy8), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy8), 64'd0);
        check("mid_rst_done", 64'(done8), 64'd0);
        check("mid_rst_sum", 64'(sum8), 64'd0);
        check("mid_rst_cout", 64'(cout8), 64'd0);
        exp_sum8 = '0; exp_cout8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 64'({busy8, done8, cout8, sum8}), 64'd0);
        end
        add8(8'h7F, 8'h01, 1'b0, 1'b0);

        // Random operands.
        for (int i = 0; i < 60; i++) begin
            add8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        // Exhaustive 4-bit sweep, back to back.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    add4(4'(x), 4'(y), 1'(c));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
